// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one signed fixed-point multiplier among N_REQ requesters.
// A two-register pipeline (operand capture, rounded product) returns each result tagged with its requester id.
module mult_share_arb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 24,
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_a,
    input  logic [N_REQ*WIDTH-1:0] i_b,
    input  logic                   i_hold,
    output logic [N_REQ-1:0]       o_gnt,
    output logic                   o_valid,
    output logic [ID_W-1:0]        o_id,
    output logic [WIDTH-1:0]       o_res,
    output logic                   o_busy
);

    localparam int unsigned SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PW    = 2 * WIDTH;

    logic [SEL_W-1:0]        ptr;
    logic                    v1;
    logic signed [WIDTH-1:0] a1;
    logic signed [WIDTH-1:0] b1;
    logic [ID_W-1:0]         id1;

    logic                    accept_c;
    logic [SEL_W-1:0]        gnt_sel_c;
    int unsigned             scan_c;
    logic [WIDTH-1:0]        a_sel_c;
    logic [WIDTH-1:0]        b_sel_c;
    logic signed [PW-1:0]    prod_c;
    logic [WIDTH-1:0]        round_c;

    // First requester at or above the pointer, wrapping; gated off by hold and reset.
    always_comb begin
        o_gnt     = '0;
        accept_c  = 1'b0;
        gnt_sel_c = '0;
        scan_c    = 0;
        if (i_rst_n && !i_hold) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                scan_c = 32'(ptr) + i;
                if (scan_c >= N_REQ) begin
                    scan_c = scan_c - N_REQ;
                end
                if (!accept_c && i_req[SEL_W'(scan_c)]) begin
                    accept_c  = 1'b1;
                    gnt_sel_c = SEL_W'(scan_c);
                end
            end
            if (accept_c) begin
                o_gnt[gnt_sel_c] = 1'b1;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        a_sel_c = '0;
        b_sel_c = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gnt_sel_c == SEL_W'(k)) begin
                a_sel_c = i_a[k*WIDTH +: WIDTH];
                b_sel_c = i_b[k*WIDTH +: WIDTH];
            end
        end
    end

    // Full-width signed product, round half up on the first discarded bit, wrap on overflow.
    always_comb begin
        prod_c  = PW'(a1) * PW'(b1);
        round_c = prod_c[FRAC+WIDTH-1:FRAC] + WIDTH'(prod_c[FRAC-1]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr     <= '0;
            v1      <= 1'b0;
            a1      <= '0;
            b1      <= '0;
            id1     <= '0;
            o_valid <= 1'b0;
            o_id    <= '0;
            o_res   <= '0;
            o_busy  <= 1'b0;
        end else if (!i_hold) begin
            v1 <= accept_c;
            if (accept_c) begin
                a1  <= a_sel_c;
                b1  <= b_sel_c;
                id1 <= ID_W'(gnt_sel_c);
                ptr <= (gnt_sel_c == SEL_W'(N_REQ - 1)) ? '0 : gnt_sel_c + SEL_W'(1);
            end
            o_valid <= v1;
            o_id    <= id1;
            o_res   <= round_c;
            // Mirrors v1 | o_valid as they will be after this edge.
            o_busy  <= accept_c | v1;
        end
    end

endmodule
